serial_mac_accumulator: RTL
===========================

# serial_mac_accumulator

Time-multiplexed multiply-accumulate stage for one equalizer band's 64-tap FIR. It consumes the frame markers `phase_0` and `phase_63` produced by the phase checker, along with one sample/coefficient pair per enabled cycle. It accumulates 64 products per frame, then rounds and saturates the sum to a 16-bit band output, raising a one-cycle valid pulse. It also flags frames that do not contain exactly 64 enabled taps.

## Interface
- `DATA_W`, 16: signed sample width (Q1.15).
- `COEF_W`, 16: signed coefficient width (Q1.15).
- `GUARD_W`, 6: accumulator guard bits (log2 of 64 taps).
- `clk` input 1: single clock. Everything is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clk_enable` input 1: cycle enable. When low, all state holds.
- `phase_0` input 1: first tap of the frame (pre-gated with `clk_enable` upstream; re-gated here).
- `phase_63` input 1: last tap of the frame (gated the same way).
- `data_in` input DATA_W: signed delay-line sample for the current tap.
- `coeff` input COEF_W: signed coefficient for the current tap.
- `filter_out` output DATA_W: signed rounded/saturated frame result. Holds between frames.
- `out_valid` output 1: one-`clk` pulse when `filter_out` updates.
- `frame_error` output 1: sticky flag for a tap-count mismatch. Cleared only by `reset`.

## Operation
- **Tap event:** `tap = clk_enable & (phase_0 | phase_63 | in_frame)`. No accumulation occurs outside a frame.
- **Product and accumulator widths:** `product = data_in * coeff`, signed, DATA_W+COEF_W = 32 bits. Accumulator `acc` is 32+GUARD_W = 38 bits signed, sign-extending the product.
- **On `clk_enable & phase_0`:**
  - `acc <= product` (load, not add).
  - `tap_cnt <= 1`.
  - `in_frame <= 1`.
- **On other enabled cycles with `in_frame`:**
  - `acc <= acc + product`.
  - `tap_cnt <= tap_cnt + 1`, 7-bit, saturating at 127.
- **On `clk_enable & phase_63` with `in_frame`:**
  - `final = acc + product`.
  - `filter_out <= sat_round(final)`.
  - `out_valid <= 1`.
  - `in_frame <= 0`.
  - If `tap_cnt != 63`, set `frame_error`.
- **Simultaneous `phase_0` and `phase_63`:** treated as a one-tap frame.
  - `filter_out <= sat_round(product)`.
  - `out_valid <= 1`.
  - `frame_error <= 1`.
  - `in_frame` stays 0.
- **`phase_0` arriving while `in_frame`:** restarts the frame. The old `acc` is discarded and `frame_error` is set.
- **`phase_63` without `in_frame`:** ignored. No output, `out_valid` stays low, `frame_error` is set.
- **`sat_round(x)`:**
  - `r = (x + 2^14) >>> 15`, arithmetic shift, computed with 39-bit intermediate.
  - Clamp to [-32768, 32767]. Round-half-up.
- **`clk_enable` low:**
  - `acc`, `tap_cnt`, `in_frame`, `filter_out` and `frame_error` all hold.
  - `out_valid` is driven 0.

## Timing
- **Reset values:** `acc = 0`, `tap_cnt = 0`, `in_frame = 0`, `filter_out = 0`, `out_valid = 0`, `frame_error = 0`. Reset is asynchronous assert, with synchronous release by the system.
- **Latency:** `filter_out` and `out_valid` update at the rising edge that samples the `phase_63` tap. Data is valid one cycle after the last tap is presented.
- **`out_valid` width:** high for exactly one `clk` period, cleared at the next edge regardless of `clk_enable`.
- **Back-to-back frames:** `phase_63` followed immediately by `phase_0` needs zero idle cycles.
- **Reset mid-frame:** the partial frame is lost and no output is produced. The next output requires a fresh `phase_0`.

## Structure
- **Shared package `eq_pkg`:** `DATA_W`, `COEF_W`, `GUARD_W`, `ACC_W = DATA_W+COEF_W+GUARD_W`, `TAPS = 64`, and the rounding constant `ROUND_BIT = 15`.
- **Sub-module `sat_round`:** combinational, ACC_W in, DATA_W out. It is reused by the other band MACs.
- **Top:** the registers, product, tap counter and error logic.

## Test plan
- **Nominal frame:** 64 taps, `data_in = 0x4000`, `coeff = 0x0100` -> `filter_out = 0x2000` (8192), one `out_valid` pulse, `frame_error = 0`.
- **Rounding:**
  - One nonzero tap at phase_0, `data_in = 1`, `coeff = 0x4000`, rest 0 -> `filter_out = 1`.
  - Same with `coeff = 0x3FFF` -> `filter_out = 0`.
- **Saturation:**
  - 64 taps of `0x7FFF * 0x7FFF` -> `0x7FFF`.
  - 64 taps of `0x8000 * 0x7FFF` -> `0x8000`.
- **`clk_enable` gaps:** random low cycles within a frame -> same result as the nominal frame, `out_valid` only on the enabled `phase_63` edge.
- **Framing faults:**
  - `phase_63` after 40 taps -> output updates, `frame_error = 1`.
  - `phase_63` with no frame -> no `out_valid`, `frame_error = 1`.
- **Reset mid-frame:** assert `reset` at tap 30 -> all outputs 0 immediately; next full frame yields the correct nominal value with `frame_error = 0`.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared widths and constants for the equalizer band MAC datapaths.
package eq_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int GUARD_W   = 6;
    localparam int ACC_W     = DATA_W + COEF_W + GUARD_W;
    localparam int TAPS      = 64;
    localparam int TAP_CNT_W = 7;
    localparam int ROUND_BIT = 15;

endpackage

// File: rtl/serial_mac_accumulator_sat_round.sv
// Round-half-up and saturate a Q-format accumulator down to a DATA_W band sample.
module sat_round #(
    parameter int ACC_W  = eq_pkg::ACC_W,
    parameter int DATA_W = eq_pkg::DATA_W
) (
    input  logic [ACC_W-1:0]  acc_in,
    output logic [DATA_W-1:0] sat_out
);
    import eq_pkg::*;

    localparam int WIDE_W = ACC_W + 1;
    localparam logic signed [WIDE_W-1:0] HALF  = WIDE_W'(1) << (ROUND_BIT - 1);
    localparam logic signed [WIDE_W-1:0] MAX_V = WIDE_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [WIDE_W-1:0] MIN_V = -WIDE_W'(2 ** (DATA_W - 1));

    // One extra bit of headroom so adding the half-LSB can never wrap.
    function automatic logic [DATA_W-1:0] sat_round_f(input logic signed [ACC_W-1:0] x);
        logic signed [WIDE_W-1:0] wide;
        logic signed [WIDE_W-1:0] shifted;
        wide    = WIDE_W'(x) + HALF;
        shifted = wide >>> ROUND_BIT;
        if (shifted > MAX_V) begin
            return MAX_V[DATA_W-1:0];
        end
        if (shifted < MIN_V) begin
            return MIN_V[DATA_W-1:0];
        end
        return shifted[DATA_W-1:0];
    endfunction

    assign sat_out = sat_round_f($signed(acc_in));

endmodule

// File: rtl/serial_mac_accumulator.sv
// Time-multiplexed 64-tap MAC for one equalizer band: accumulates a frame of
// products, emits a rounded/saturated result pulse and flags miscounted frames.
module serial_mac_accumulator #(
    parameter int DATA_W  = eq_pkg::DATA_W,
    parameter int COEF_W  = eq_pkg::COEF_W,
    parameter int GUARD_W = eq_pkg::GUARD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              phase_0,
    input  logic              phase_63,
    input  logic [DATA_W-1:0] data_in,
    input  logic [COEF_W-1:0] coeff,
    output logic [DATA_W-1:0] filter_out,
    output logic              out_valid,
    output logic              frame_error
);
    import eq_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + GUARD_W;
    localparam logic [TAP_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TAP_CNT_W-1:0] CNT_LAST = TAP_CNT_W'(TAPS - 1);

    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]          round_in;
    logic [DATA_W-1:0]         round_out;
    logic                      start;
    logic                      last;
    logic [TAP_CNT_W-1:0]      tap_cnt_inc;

    logic signed [ACC_W-1:0]   acc_d, acc_q;
    logic [TAP_CNT_W-1:0]      tap_cnt_d, tap_cnt_q;
    logic                      in_frame_d, in_frame_q;
    logic [DATA_W-1:0]         filter_out_d, filter_out_q;
    logic                      out_valid_d, out_valid_q;
    logic                      frame_error_d, frame_error_q;

    assign product     = PROD_W'($signed(data_in)) * PROD_W'($signed(coeff));
    assign product_ext = ACC_W'(product);
    assign acc_sum     = acc_q + product_ext;
    assign start       = clk_enable & phase_0;
    assign last        = clk_enable & phase_63;
    assign tap_cnt_inc = (tap_cnt_q == CNT_MAX) ? tap_cnt_q : tap_cnt_q + 1'b1;

    // A one-tap frame rounds the bare product; otherwise the frame total.
    assign round_in = (start & last) ? product_ext : acc_sum;

    sat_round #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W)
    ) u_sat_round (
        .acc_in (round_in),
        .sat_out(round_out)
    );

    always_comb begin
        acc_d         = acc_q;
        tap_cnt_d     = tap_cnt_q;
        in_frame_d    = in_frame_q;
        filter_out_d  = filter_out_q;
        out_valid_d   = 1'b0;
        frame_error_d = frame_error_q;

        if (start) begin
            acc_d      = product_ext;
            tap_cnt_d  = 1;
            in_frame_d = 1'b1;
            if (in_frame_q) begin
                frame_error_d = 1'b1;
            end
            if (last) begin
                filter_out_d  = round_out;
                out_valid_d   = 1'b1;
                in_frame_d    = 1'b0;
                frame_error_d = 1'b1;
            end
        end else if (last) begin
            if (in_frame_q) begin
                acc_d        = acc_sum;
                tap_cnt_d    = tap_cnt_inc;
                filter_out_d = round_out;
                out_valid_d  = 1'b1;
                in_frame_d   = 1'b0;
                if (tap_cnt_q != CNT_LAST) begin
                    frame_error_d = 1'b1;
                end
            end else begin
                frame_error_d = 1'b1;
            end
        end else if (clk_enable && in_frame_q) begin
            acc_d     = acc_sum;
            tap_cnt_d = tap_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            tap_cnt_q     <= '0;
            in_frame_q    <= 1'b0;
            filter_out_q  <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            tap_cnt_q     <= tap_cnt_d;
            in_frame_q    <= in_frame_d;
            filter_out_q  <= filter_out_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign filter_out  = filter_out_q;
    assign out_valid   = out_valid_q;
    assign frame_error = frame_error_q;

endmodule
